// File: rtl/legv8_pkg.sv
// Shared constants and types for the LEGv8 multi-cycle control unit.
// Opcodes, ALU function-select codes, ControlWord field offsets and FSM states.
package legv8_pkg;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_EOR  = 11'b11001010000;
    localparam logic [10:0] OP_LSL  = 11'b11010011011;
    localparam logic [10:0] OP_LSR  = 11'b11010011010;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    localparam logic [9:0] OP_ADDI = 10'b1001000100;
    localparam logic [9:0] OP_SUBI = 10'b1101000100;
    localparam logic [9:0] OP_ANDI = 10'b1001001000;
    localparam logic [9:0] OP_ORRI = 10'b1011001000;
    localparam logic [9:0] OP_EORI = 10'b1101001000;

    localparam logic [7:0] OP_CBZ  = 8'b10110100;
    localparam logic [7:0] OP_CBNZ = 8'b10110101;
    localparam logic [5:0] OP_B    = 6'b000101;

    // FS[4:2] = operation, FS[1] = Binvert, FS[0] = Ainvert
    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_OR  = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01010;
    localparam logic [4:0] FS_XOR = 5'b01100;
    localparam logic [4:0] FS_LSL = 5'b10000;
    localparam logic [4:0] FS_LSR = 5'b10100;

    localparam int CW_DA   = 20;
    localparam int CW_SA   = 15;
    localparam int CW_SB   = 10;
    localparam int CW_FS   = 5;
    localparam int CW_C0   = 4;
    localparam int CW_W    = 3;
    localparam int CW_BSEL = 2;
    localparam int CW_MW   = 1;
    localparam int CW_EN   = 0;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_MEM   = 2'd2;
    localparam logic [1:0] ST_CHECK = 2'd3;

    typedef enum logic [3:0] {
        CL_RTYPE, CL_IMM, CL_SHIFT, CL_LOAD, CL_STORE,
        CL_CBZ, CL_CBNZ, CL_B, CL_ILLEGAL
    } instr_class_e;

    typedef struct packed {
        logic [24:0]  cw;
        logic [63:0]  constant;
        logic [63:0]  offset;
        instr_class_e cls;
    } decode_t;

    function automatic logic [24:0] make_cw(
        input logic [4:0] da, input logic [4:0] sa, input logic [4:0] sb,
        input logic [4:0] fs, input logic c0, input logic w_reg,
        input logic b_sel, input logic mw, input logic en_mem);
        return {da, sa, sb, fs, c0, w_reg, b_sel, mw, en_mem};
    endfunction

endpackage

// File: rtl/legv8_decoder.sv
// Combinational decode of the instruction register into the EXEC-phase
// ControlWord, datapath constant, PC offset and instruction class.
module legv8_decoder
    import legv8_pkg::*;
(
    input  logic [31:0] ir,
    output decode_t     dec
);

    logic [4:0]   rd, rn, rm;
    logic [63:0]  imm12, shamt, dt_addr, br26, br19;
    instr_class_e cls;
    logic [4:0]   fs;
    logic         c0;

    assign rd      = ir[4:0];
    assign rn      = ir[9:5];
    assign rm      = ir[20:16];
    assign imm12   = {52'd0, ir[21:10]};
    assign shamt   = {58'd0, ir[15:10]};
    assign dt_addr = {{55{ir[20]}}, ir[20:12]};
    assign br26    = {{36{ir[25]}}, ir[25:0], 2'b00};
    assign br19    = {{43{ir[23]}}, ir[23:5], 2'b00};

    // Longest opcode prefix wins: each shorter match only runs as the fallback.
    always_comb begin
        cls = CL_ILLEGAL;
        fs  = FS_ADD;
        c0  = 1'b0;
        case (ir[31:21])
            OP_ADD:  begin cls = CL_RTYPE; fs = FS_ADD; end
            OP_SUB:  begin cls = CL_RTYPE; fs = FS_SUB; c0 = 1'b1; end
            OP_AND:  begin cls = CL_RTYPE; fs = FS_AND; end
            OP_ORR:  begin cls = CL_RTYPE; fs = FS_OR;  end
            OP_EOR:  begin cls = CL_RTYPE; fs = FS_XOR; end
            OP_LSL:  begin cls = CL_SHIFT; fs = FS_LSL; end
            OP_LSR:  begin cls = CL_SHIFT; fs = FS_LSR; end
            OP_LDUR: cls = CL_LOAD;
            OP_STUR: cls = CL_STORE;
            default: begin
                case (ir[31:22])
                    OP_ADDI: begin cls = CL_IMM; fs = FS_ADD; end
                    OP_SUBI: begin cls = CL_IMM; fs = FS_SUB; c0 = 1'b1; end
                    OP_ANDI: begin cls = CL_IMM; fs = FS_AND; end
                    OP_ORRI: begin cls = CL_IMM; fs = FS_OR;  end
                    OP_EORI: begin cls = CL_IMM; fs = FS_XOR; end
                    default: begin
                        case (ir[31:24])
                            OP_CBZ:  cls = CL_CBZ;
                            OP_CBNZ: cls = CL_CBNZ;
                            default: if (ir[31:26] == OP_B) cls = CL_B;
                        endcase
                    end
                endcase
            end
        endcase
    end

    always_comb begin
        dec        = '0;
        dec.cls    = cls;
        dec.offset = (cls == CL_B) ? br26 : br19;
        case (cls)
            CL_RTYPE: dec.cw = make_cw(rd, rn, rm, fs, c0, 1'b1, 1'b0, 1'b0, 1'b0);
            CL_IMM: begin
                dec.cw       = make_cw(rd, rn, 5'd0, fs, c0, 1'b1, 1'b1, 1'b0, 1'b0);
                dec.constant = imm12;
            end
            CL_SHIFT: begin
                dec.cw       = make_cw(rd, rn, 5'd0, fs, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
                dec.constant = shamt;
            end
            CL_LOAD, CL_STORE: begin
                dec.cw       = make_cw(5'd0, rn, 5'd0, FS_ADD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
                dec.constant = dt_addr;
            end
            CL_CBZ, CL_CBNZ:
                dec.cw = make_cw(5'd0, 5'd31, rd, FS_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            default: ;
        endcase
    end

endmodule

// File: rtl/legv8_control_unit.sv
// Multi-cycle LEGv8 control unit: instruction handshake, FSM, PC and the
// ControlWord/constant that drive DatapathLEGv8.
module legv8_control_unit
    import legv8_pkg::*;
#(
    parameter logic [63:0] PC_RESET = 64'd0,
    parameter logic [63:0] PC_STEP  = 64'd4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [3:0]  status,
    output logic [24:0] ControlWord,
    output logic [63:0] constant,
    output logic [63:0] pc,
    output logic        illegal
);

    logic [1:0]  state;
    logic [31:0] ir;
    decode_t     dec;
    logic        take;
    logic        status_unused;

    legv8_decoder u_dec (
        .ir  (ir),
        .dec (dec)
    );

    assign status_unused = ^status[3:1];
    assign take = (dec.cls == CL_CBZ  &&  status[0]) ||
                  (dec.cls == CL_CBNZ && !status[0]);
    assign instr_ready = (state == ST_FETCH);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_FETCH;
            ir    <= '0;
            pc    <= PC_RESET;
        end else begin
            case (state)
                ST_FETCH: if (instr_valid) begin
                    ir    <= instruction;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    case (dec.cls)
                        CL_LOAD, CL_STORE: state <= ST_MEM;
                        CL_CBZ, CL_CBNZ:   state <= ST_CHECK;
                        CL_B: begin
                            pc    <= pc + dec.offset;
                            state <= ST_FETCH;
                        end
                        default: begin
                            pc    <= pc + PC_STEP;
                            state <= ST_FETCH;
                        end
                    endcase
                end
                ST_MEM: begin
                    pc    <= pc + PC_STEP;
                    state <= ST_FETCH;
                end
                default: begin
                    pc    <= take ? pc + dec.offset : pc + PC_STEP;
                    state <= ST_FETCH;
                end
            endcase
        end
    end

    // Outputs derive from state, so an async reset zeroes them without waiting for a clock.
    always_comb begin
        ControlWord = '0;
        constant    = '0;
        illegal     = 1'b0;
        case (state)
            ST_EXEC: begin
                ControlWord = dec.cw;
                constant    = dec.constant;
                illegal     = (dec.cls == CL_ILLEGAL);
            end
            ST_MEM: begin
                ControlWord = dec.cw;
                constant    = dec.constant;
                if (dec.cls == CL_LOAD) begin
                    ControlWord[CW_DA +: 5] = ir[4:0];
                    ControlWord[CW_W]       = 1'b1;
                    ControlWord[CW_EN]      = 1'b1;
                end else begin
                    ControlWord[CW_SB +: 5] = ir[4:0];
                    ControlWord[CW_MW]      = 1'b1;
                end
            end
            ST_CHECK: begin
                ControlWord = dec.cw;
                constant    = dec.constant;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_legv8_control_unit.sv
// Randomized self-checking bench for legv8_control_unit: a transaction-level model
// expands each accepted instruction into its expected per-cycle outputs.
module tb_legv8_control_unit;

    typedef struct {
        logic        rdy;
        logic [24:0] cw;
        logic [63:0] k;
        logic [63:0] pc;
        logic        ill;
    } rec_t;

    logic        clock;
    logic        reset;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  status;
    logic [24:0] ControlWord;
    logic [63:0] constant;
    logic [63:0] pc;
    logic        illegal;

    int   n_cmp = 0;
    int   n_bad = 0;
    rec_t exp_q[$];
    rec_t future[$];
    logic [63:0] pc_m, pc_nx;
    logic [31:0] ins;
    logic [3:0]  st;

    legv8_control_unit #(.PC_RESET(64'd0), .PC_STEP(64'd4)) dut (
        .clock       (clock),
        .reset       (reset),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .status      (status),
        .ControlWord (ControlWord),
        .constant    (constant),
        .pc          (pc),
        .illegal     (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [24:0] cwf(
        input logic [4:0] da, input logic [4:0] sa, input logic [4:0] sb,
        input logic [4:0] fs, input logic c0, input logic w,
        input logic b, input logic mw, input logic en);
        return {da, sa, sb, fs, c0, w, b, mw, en};
    endfunction

    // Expand one accepted instruction into the records for its busy cycles.
    task automatic model_accept(input logic [31:0] i, input logic [3:0] s);
        rec_t        r;
        logic [24:0] cw, mcw;
        logic [63:0] k, npc;
        logic        ill, extra;
        logic [4:0]  rd, rn, rm;
        rd = i[4:0]; rn = i[9:5]; rm = i[20:16];
        cw = '0; mcw = '0; k = '0; ill = 1'b0; extra = 1'b0;
        npc = pc_m + 64'd4;
        if      (i[31:21] == 11'b10001011000) cw = cwf(rd, rn, rm, 5'b01000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        else if (i[31:21] == 11'b11001011000) cw = cwf(rd, rn, rm, 5'b01010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        else if (i[31:21] == 11'b10001010000) cw = cwf(rd, rn, rm, 5'b00000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        else if (i[31:21] == 11'b10101010000) cw = cwf(rd, rn, rm, 5'b00100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        else if (i[31:21] == 11'b11001010000) cw = cwf(rd, rn, rm, 5'b01100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        else if (i[31:21] == 11'b11010011011 || i[31:21] == 11'b11010011010) begin
            cw = cwf(rd, rn, 5'd0, i[21] ? 5'b10000 : 5'b10100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            k  = 64'(i[15:10]);
        end else if (i[31:21] == 11'b11111000010 || i[31:21] == 11'b11111000000) begin
            cw  = cwf(5'd0, rn, 5'd0, 5'b01000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            k   = 64'($signed(i[20:12]));
            mcw = i[22] ? (cw | cwf(rd, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1))
                        : (cw | cwf(5'd0, 5'd0, rd, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
            extra = 1'b1;
        end else if (i[31:22] == 10'b1001000100 || i[31:22] == 10'b1101000100 ||
                     i[31:22] == 10'b1001001000 || i[31:22] == 10'b1011001000 ||
                     i[31:22] == 10'b1101001000) begin
            case (i[31:22])
                10'b1001000100: cw = cwf(rd, rn, 5'd0, 5'b01000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
                10'b1101000100: cw = cwf(rd, rn, 5'd0, 5'b01010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
                10'b1001001000: cw = cwf(rd, rn, 5'd0, 5'b00000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
                10'b1011001000: cw = cwf(rd, rn, 5'd0, 5'b00100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
                default:        cw = cwf(rd, rn, 5'd0, 5'b01100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            endcase
            k = 64'(i[21:10]);
        end else if (i[31:25] == 7'b1011010) begin
            cw    = cwf(5'd0, 5'd31, rd, 5'b01000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            mcw   = cw;
            extra = 1'b1;
            if ((i[24] == 1'b0 && s[0]) || (i[24] == 1'b1 && !s[0]))
                npc = pc_m + 64'($signed(i[23:5])) * 64'd4;
        end else if (i[31:26] == 6'b000101) begin
            npc = pc_m + 64'($signed(i[25:0])) * 64'd4;
        end else begin
            ill = 1'b1;
        end
        r.rdy = 1'b0; r.cw = cw; r.k = k; r.pc = pc_m; r.ill = ill;
        future.push_back(r);
        if (extra) begin
            r.cw = mcw; r.ill = 1'b0;
            future.push_back(r);
        end
        pc_nx = npc;
    endtask

    // One clock cycle of stimulus plus the expectation for that cycle.
    task automatic step(input logic v, input logic [31:0] i, input logic [3:0] s);
        rec_t r;
        @(posedge clock); #1;
        instr_valid = v; instruction = i; status = s;
        if (future.size() == 0) begin
            r.rdy = 1'b1; r.cw = '0; r.k = '0; r.pc = pc_m; r.ill = 1'b0;
            exp_q.push_back(r);
            if (v) model_accept(i, s);
        end else begin
            r = future.pop_front();
            exp_q.push_back(r);
            if (future.size() == 0) pc_m = pc_nx;
        end
    endtask

    task automatic run_chk(input logic [31:0] i, input logic [3:0] s, input string nm,
                           input logic [63:0] exp_pc);
        step(1'b1, i, s);
        while (future.size() > 0) step(1'b0, 32'h0, s);
        step(1'b0, 32'h0, s);
        @(negedge clock);
        check(nm, pc, exp_pc);
    endtask

    task automatic do_reset();
        #2;
        exp_q.delete();
        future.delete();
        pc_m = 64'd0;
        reset = 1'b1; instr_valid = 1'b0;
        #1;
        check("rst_ready", 64'(instr_ready), 64'd1);
        check("rst_cw", 64'(ControlWord), 64'd0);
        check("rst_pc", pc, 64'd0);
        check("rst_const", constant, 64'd0);
        check("rst_illegal", 64'(illegal), 64'd0);
        @(posedge clock); #2;
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 17))
            0:  r[31:21] = 11'b10001011000;
            1:  r[31:21] = 11'b11001011000;
            2:  r[31:21] = 11'b10001010000;
            3:  r[31:21] = 11'b10101010000;
            4:  r[31:21] = 11'b11001010000;
            5:  r[31:21] = 11'b11010011011;
            6:  r[31:21] = 11'b11010011010;
            7:  r[31:21] = 11'b11111000010;
            8:  r[31:21] = 11'b11111000000;
            9:  r[31:22] = 10'b1001000100;
            10: r[31:22] = 10'b1101000100;
            11: r[31:22] = 10'b1001001000;
            12: r[31:22] = 10'b1011001000;
            13: r[31:22] = 10'b1101001000;
            14: r[31:24] = 8'b10110100;
            15: r[31:24] = 8'b10110101;
            16: r[31:26] = 6'b000101;
            default: ;
        endcase
        return r;
    endfunction

    always @(negedge clock) begin : cmp
        rec_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("instr_ready", 64'(instr_ready), 64'(e.rdy));
            check("ControlWord", 64'(ControlWord), 64'(e.cw));
            check("constant", constant, e.k);
            check("pc", pc, e.pc);
            check("illegal", 64'(illegal), 64'(e.ill));
        end
    end

    initial begin
        reset = 1'b1; instr_valid = 1'b0; instruction = '0; status = '0;
        pc_m = '0; pc_nx = '0;
        @(posedge clock); #1;
        do_reset();

        // ADD X3,X1,X2
        step(1'b1, 32'h8B020023, 4'h0);
        step(1'b0, 32'h0, 4'h0);
        @(negedge clock);
        check("add_cw", 64'(ControlWord), 64'h308908);
        check("add_busy", 64'(instr_ready), 64'd0);
        step(1'b0, 32'h0, 4'h0);
        @(negedge clock);
        check("add_pc", pc, 64'd4);
        check("add_ready_again", 64'(instr_ready), 64'd1);

        // ADDI X1,X31,#256
        step(1'b1, 32'h910403E1, 4'h0);
        step(1'b0, 32'h0, 4'h0);
        @(negedge clock);
        check("addi_const", constant, 64'd256);
        check("addi_cw", 64'(ControlWord), 64'h1F810C);
        step(1'b0, 32'h0, 4'h0);

        // LDUR X5,[X2,#-8]
        step(1'b1, 32'hF85F8045, 4'h0);
        step(1'b0, 32'h0, 4'h0);
        @(negedge clock);
        check("ldur_const", constant, 64'hFFFF_FFFF_FFFF_FFF8);
        check("ldur_exec_cw", 64'(ControlWord), 64'h010104);
        step(1'b0, 32'h0, 4'h0);
        @(negedge clock);
        check("ldur_mem_cw", 64'(ControlWord), 64'h51010D);
        step(1'b0, 32'h0, 4'h0);
        @(negedge clock);
        check("ldur_pc", pc, 64'd12);

        run_chk(32'hB4000064, 4'b0001, "cbz_taken_pc", 64'd24);
        run_chk(32'hB4000064, 4'b0000, "cbz_fall_pc", 64'd28);
        run_chk(32'hB5000064, 4'b0001, "cbnz_fall_pc", 64'd32);
        run_chk(32'hB5000064, 4'b0000, "cbnz_taken_pc", 64'd44);

        step(1'b1, 32'hFFFF_FFFF, 4'h0);
        step(1'b0, 32'h0, 4'h0);
        @(negedge clock);
        check("illegal_pulse", 64'(illegal), 64'd1);
        check("illegal_cw", 64'(ControlWord), 64'd0);
        step(1'b0, 32'h0, 4'h0);
        @(negedge clock);
        check("illegal_done", 64'(illegal), 64'd0);
        check("illegal_pc", pc, 64'd48);

        // Reset during EXEC of a store, then confirm quiet FETCH cycles.
        step(1'b1, 32'hF8000045, 4'h0);
        step(1'b0, 32'h0, 4'h0);
        do_reset();
        repeat (3) step(1'b0, 32'h0, 4'h0);

        // B #-1 from pc 0 wraps
        run_chk(32'h17FF_FFFF, 4'h0, "b_wrap_pc", 64'hFFFF_FFFF_FFFF_FFFC);

        for (int n = 0; n < 250; n++) begin
            ins = rand_instr();
            st  = 4'($urandom);
            repeat ($urandom_range(0, 2)) step(1'b0, $urandom, st);
            step(1'b1, ins, st);
            while (future.size() > 0) step(1'($urandom), $urandom, st);
        end
        step(1'b0, 32'h0, 4'h0);
        step(1'b0, 32'h0, 4'h0);
        @(negedge clock); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
